hs32_sram_bank_ctrl: RTL and testbench

HS32_SRAM_BANK_CTRL -- requirements
Module: hs32_sram_bank_ctrl

---
 rtl/hs32_sram_pkg.sv | 23 ++
 rtl/hs32_rr_arb2.sv | 32 +++
 rtl/hs32_sram_bank_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hs32_sram_bank_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs32_sram_pkg.sv
// Shared types and constants for the hs32 SRAM bank controller.
package hs32_sram_pkg;

  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  // Controller sequencing: grant in IDLE, macro read data arrives in ACC,
  // response pulse in RESP.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // One memory request as seen by the bank decoder, from either port.
  typedef struct packed {
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] mask;
  } req_t;

endpackage

// File: rtl/hs32_rr_arb2.sv
// Two-requester round-robin arbiter. Requester 0 is the CPU, requester 1 the
// Wishbone slave. On a tie the requester that did not win last time wins;
// out of reset requester 0 wins the first tie.
module hs32_rr_arb2 (
  input  logic       wb_clk_i,
  input  logic       wb_rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;  // 1: requester 1 was granted most recently

  // Grant selection, only while the controller can accept.
  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (en_i) begin
      if (&req_i) gnt_o = last_q ? 2'b01 : 2'b10;
      else        gnt_o = req_i;
    end
    if (gnt_o[0])      last_d = 1'b0;
    else if (gnt_o[1]) last_d = 1'b1;
  end

  // Pointer register; reset value makes the CPU win the first tie.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) last_q <= 1'b1;
    else            last_q <= last_d;
  end

endmodule

// File: rtl/hs32_sram_bank_ctrl.sv
// Bank controller in front of NBANKS 32-bit OpenRAM macros, shared between a
// simple CPU request port and an optional Wishbone classic slave.
// Optional feature macro: HS32_SRAM_WB_PORT_EN enables the Wishbone port; when
// undefined the WB inputs are ignored and the CPU owns the banks.
module hs32_sram_bank_ctrl
  import hs32_sram_pkg::*;
#(
  parameter int NBANKS = 4,
  parameter int ADDR_W = 8,
  parameter int BANK_W = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_ni,
  input  logic                           cpu_valid,
  input  logic                           cpu_we,
  input  logic [31:0]                    cpu_addr,
  input  logic [DATA_W-1:0]              cpu_wdata,
  input  logic [MASK_W-1:0]              cpu_wmask,
  output logic                           cpu_ready,
  output logic                           cpu_rvalid,
  output logic                           cpu_err,
  output logic [DATA_W-1:0]              cpu_rdata,
  input  logic                           wbs_cyc_i,
  input  logic                           wbs_stb_i,
  input  logic                           wbs_we_i,
  input  logic [MASK_W-1:0]              wbs_sel_i,
  input  logic [31:0]                    wbs_adr_i,
  input  logic [DATA_W-1:0]              wbs_dat_i,
  output logic                           wbs_ack_o,
  output logic [DATA_W-1:0]              wbs_dat_o,
  output logic [NBANKS-1:0]              ram_csb,
  output logic [NBANKS-1:0]              ram_web,
  output logic [NBANKS-1:0][MASK_W-1:0]  ram_wmask,
  output logic [ADDR_W-1:0]              ram_addr,
  output logic [DATA_W-1:0]              ram_din,
  input  logic [NBANKS-1:0][DATA_W-1:0]  ram_dout
);

  localparam int TOP_LSB = ADDR_W + BANK_W + 2;

  state_e              state_q, state_d;
  req_t                cpu_req, wb_req, sel_req;
  logic                wb_cyc, wb_stb_req;
  logic                arb_en, grant;
  logic [1:0]          gnt;
  logic [ADDR_W-1:0]   sel_word;
  logic [BANK_W-1:0]   sel_bank, bank_q;
  logic                sel_err;
  logic                own_wb_q, we_q, err_q, cyc_ok_q;
  logic [DATA_W-1:0]   cpu_rdata_q, wb_rdata_q, rd_word;
  logic                unused_lsb;

  assign cpu_req = {cpu_we, cpu_addr, cpu_wdata, cpu_wmask};

`ifdef HS32_SRAM_WB_PORT_EN
  assign wb_cyc     = wbs_cyc_i;
  assign wb_stb_req = wbs_cyc_i & wbs_stb_i;
  assign wb_req     = {wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i};
`else
  logic unused_wb;
  assign wb_cyc     = 1'b0;
  assign wb_stb_req = 1'b0;
  assign wb_req     = '0;
  assign unused_wb  = ^{wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i};
`endif

  // Reset gates the arbiter so no chip-select can leak out while held in reset.
  assign arb_en = (state_q == ST_IDLE) && wb_rst_ni;

  hs32_rr_arb2 u_arb (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .en_i      (arb_en),
    .req_i     ({wb_stb_req, cpu_valid}),
    .gnt_o     (gnt)
  );

  assign grant   = |gnt;
  assign sel_req = gnt[1] ? wb_req : cpu_req;

  // Byte address split: word in bank, bank select, and out-of-range detection.
  assign sel_word   = sel_req.addr[ADDR_W+1:2];
  assign sel_bank   = sel_req.addr[TOP_LSB-1:ADDR_W+2];
  assign sel_err    = (|sel_req.addr[31:TOP_LSB]) || (32'(sel_bank) >= 32'(NBANKS));
  assign unused_lsb = ^sel_req.addr[1:0];

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next state: fixed three-cycle access once granted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant) state_d = ST_ACC;
      ST_ACC:  state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the granted request so later input changes do not disturb it; a
  // dropped cyc during the access cancels the WB acknowledge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      own_wb_q <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      bank_q   <= '0;
      cyc_ok_q <= 1'b0;
    end else if (grant) begin
      own_wb_q <= gnt[1];
      we_q     <= sel_req.we;
      err_q    <= sel_err;
      bank_q   <= sel_bank;
      cyc_ok_q <= 1'b1;
    end else if (state_q != ST_IDLE && !wb_cyc) begin
      cyc_ok_q <= 1'b0;
    end
  end

  assign rd_word = err_q ? '0 : ram_dout[bank_q];

  // Register macro read data at the end of ACC into the owning port's holding
  // register; decode errors load zero. Writes leave the held data alone.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cpu_rdata_q <= '0;
      wb_rdata_q  <= '0;
    end else if (state_q == ST_ACC && (!we_q || err_q)) begin
      if (own_wb_q) wb_rdata_q  <= rd_word;
      else          cpu_rdata_q <= rd_word;
    end
  end

  // Outputs: macro strobes in the grant cycle, response pulses in RESP.
  always_comb begin
    cpu_ready = gnt[0];
    ram_csb   = '1;
    ram_web   = '1;
    ram_wmask = '0;
    ram_addr  = '0;
    ram_din   = '0;
    if (grant) begin
      ram_addr = sel_word;
      ram_din  = sel_req.wdata;
      if (!sel_err) begin
        ram_csb[sel_bank]   = 1'b0;
        ram_web[sel_bank]   = ~sel_req.we;
        ram_wmask[sel_bank] = sel_req.mask;
      end
    end
    cpu_rvalid = (state_q == ST_RESP) && !own_wb_q;
    cpu_err    = (state_q == ST_RESP) && !own_wb_q && err_q;
    wbs_ack_o  = (state_q == ST_RESP) && own_wb_q && cyc_ok_q && wb_cyc;
  end

  assign cpu_rdata = cpu_rdata_q;
  assign wbs_dat_o = wb_rdata_q;

endmodule

// File: tb/tb_hs32_sram_bank_ctrl.sv
// Self-checking bench for hs32_sram_bank_ctrl (NBANKS=4, ADDR_W=8).
// Behavioural SRAM macros plus a flat word-array reference memory.
module tb_hs32_sram_bank_ctrl;

  localparam int NB         = 4;
  localparam int AW         = 8;
  localparam int NWORDS     = NB * (1 << AW);
  localparam int BANK_BYTES = 4 * (1 << AW);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 cpu_valid, cpu_we;
  logic [31:0]          cpu_addr, cpu_wdata;
  logic [3:0]           cpu_wmask;
  logic                 cpu_ready, cpu_rvalid, cpu_err;
  logic [31:0]          cpu_rdata;
  logic                 wbs_cyc, wbs_stb, wbs_we;
  logic [3:0]           wbs_sel;
  logic [31:0]          wbs_adr, wbs_dat_w;
  logic                 wbs_ack;
  logic [31:0]          wbs_dat_r;
  logic [NB-1:0]        ram_csb, ram_web;
  logic [NB-1:0][3:0]   ram_wmask;
  logic [AW-1:0]        ram_addr;
  logic [31:0]          ram_din;
  logic [NB-1:0][31:0]  ram_dout;

  int checks = 0;
  int failures = 0;

  hs32_sram_bank_ctrl #(.NBANKS(NB), .ADDR_W(AW)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .wbs_cyc_i(wbs_cyc), .wbs_stb_i(wbs_stb), .wbs_we_i(wbs_we), .wbs_sel_i(wbs_sel),
    .wbs_adr_i(wbs_adr), .wbs_dat_i(wbs_dat_w), .wbs_ack_o(wbs_ack), .wbs_dat_o(wbs_dat_r),
    .ram_csb(ram_csb), .ram_web(ram_web), .ram_wmask(ram_wmask),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Behavioural OpenRAM macros: sample on the rising edge, read data next cycle.
  logic [31:0] mem [NB][1<<AW];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int b = 0; b < NB; b++)
        for (int w = 0; w < (1 << AW); w++) mem[b][w] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (!ram_csb[b]) begin
          if (!ram_web[b]) begin
            for (int l = 0; l < 4; l++)
              if (ram_wmask[b][l]) mem[b][ram_addr][8*l +: 8] <= ram_din[8*l +: 8];
          end else begin
            ram_dout[b] <= mem[b][ram_addr];
          end
        end
      end
    end
  end

  // Reference: the whole address space as a flat array of words.
  logic [31:0] refmem [NWORDS];

  function automatic bit is_err(logic [31:0] a);
    return a >= 32'(NWORDS * 4);
  endfunction

  function automatic int bank_of(logic [31:0] a);
    return int'(a / 32'(BANK_BYTES));
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < 4; l++) if (m[l]) r[8*l +: 8] = nw[8*l +: 8];
    return r;
  endfunction

  task automatic ref_apply(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    if (we && !is_err(a)) refmem[int'(a / 4)] = merge(refmem[int'(a / 4)], d, m);
  endtask

  function automatic logic [31:0] ref_read(logic [31:0] a);
    return is_err(a) ? 32'h0 : refmem[int'(a / 4)];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One CPU access with protocol checks; returns the response data and error.
  task automatic cpu_xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input string nm,
                          output logic [31:0] rd, output logic er);
    int n;
    logic [NB-1:0] exp_csb;
    rd = '0;
    er = 1'b0;
    @(negedge clk);
    cpu_valid = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_wmask = m;
    #1;
    n = 0;
    while (!cpu_ready && n < 10) begin @(negedge clk); #1; n++; end
    chk({nm, " ready"}, 64'(cpu_ready), 64'd1);
    if (!cpu_ready) begin cpu_valid = 1'b0; return; end
    exp_csb = '1;
    if (!is_err(a)) exp_csb[bank_of(a)] = 1'b0;
    chk({nm, " csb"}, 64'(ram_csb), 64'(exp_csb));
    if (!is_err(a)) chk({nm, " ram_addr"}, 64'(ram_addr), 64'((a / 4) % (1 << AW)));
    @(posedge clk); #1;
    cpu_valid = 1'b0; cpu_we = 1'($urandom); cpu_addr = $urandom;
    cpu_wdata = $urandom; cpu_wmask = 4'($urandom);
    @(negedge clk);
    chk({nm, " early rvalid"}, 64'(cpu_rvalid), 64'd0);
    @(negedge clk);
    chk({nm, " rvalid"}, 64'(cpu_rvalid), 64'd1);
    rd = cpu_rdata;
    er = cpu_err;
    @(negedge clk);
    chk({nm, " rvalid pulse"}, 64'(cpu_rvalid), 64'd0);
  endtask

`ifdef HS32_SRAM_WB_PORT_EN
  // One Wishbone classic cycle; returns read data captured with ack.
  task automatic wb_xfer(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] sel, input string nm, output logic [31:0] rd);
    int n;
    @(negedge clk);
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = we; wbs_adr = a; wbs_dat_w = d; wbs_sel = sel;
    #1;
    n = 0;
    while (!wbs_ack && n < 12) begin @(negedge clk); n++; end
    chk({nm, " ack"}, 64'(wbs_ack), 64'd1);
    rd = wbs_dat_r;
    @(posedge clk); #1;
    wbs_cyc = 1'b0; wbs_stb = 1'b0;
  endtask
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          pulses;

    tbl[0]  = '{1'b1, 32'h0000_0404, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h0000_0404, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h0000_0808, 32'h11223344, 4'hF, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 32'h0000_0808, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 32'h0000_0808, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    tbl[5]  = '{1'b0, 32'h0000_1000, 32'h0,        4'h0, 32'h0,        1'b1};
    tbl[6]  = '{1'b1, 32'h0000_1000, 32'h5A5A5A5A, 4'hF, 32'h0,        1'b1};
    tbl[7]  = '{1'b1, 32'h0000_0FFC, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    tbl[8]  = '{1'b0, 32'h0000_0FFC, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    tbl[9]  = '{1'b0, 32'h0000_0000, 32'h0,        4'h0, 32'h0,        1'b0};
    tbl[10] = '{1'b1, 32'h0000_0000, 32'h12345678, 4'h0, 32'h0,        1'b0};
    tbl[11] = '{1'b0, 32'h0000_0000, 32'h0,        4'h0, 32'h0,        1'b0};
    tbl[12] = '{1'b0, 32'h8000_0404, 32'h0,        4'h0, 32'h0,        1'b1};

    for (int i = 0; i < NWORDS; i++) refmem[i] = '0;

    // Reset with requests pending on both ports: nothing may leak out.
    rst_n = 1'b0; mem_clr = 1'b1;
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h404; cpu_wdata = '1; cpu_wmask = 4'hF;
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1; wbs_adr = 32'h808; wbs_dat_w = '1; wbs_sel = 4'hF;
    repeat (3) @(negedge clk);
    chk("reset ready", 64'(cpu_ready), 64'd0);
    chk("reset csb/web", 64'({ram_csb, ram_web}), 64'({2*NB{1'b1}}));
    chk("reset wmask/addr/din", 64'({ram_wmask, ram_addr, ram_din}), 64'd0);
    chk("reset resp", 64'({cpu_rvalid, cpu_err, wbs_ack}), 64'd0);
    chk("reset data", {cpu_rdata, wbs_dat_r}, 64'd0);
    cpu_valid = 1'b0; wbs_cyc = 1'b0; wbs_stb = 1'b0;
    mem_clr = 1'b0;
    rst_n = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 13; i++) begin
      cpu_xfer(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].mask, $sformatf("vec%0d", i), rd, er);
      chk($sformatf("vec%0d err", i), 64'(er), 64'(tbl[i].exp_err));
      if (!tbl[i].we) chk($sformatf("vec%0d rdata", i), 64'(rd), 64'(tbl[i].exp_rdata));
      ref_apply(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].mask);
    end

    // Reset during ACC: immediate reset values, no response afterwards.
    cpu_xfer(1'b0, 32'h404, 32'h0, 4'h0, "pre-abort", rd, er);
    chk("pre-abort rdata", 64'(rd), 64'(ref_read(32'h404)));
    @(negedge clk);
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h808;
    #1 chk("abort ready", 64'(cpu_ready), 64'd1);
    @(posedge clk); #1 cpu_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort rdata", 64'(cpu_rdata), 64'd0);
    chk("abort csb", 64'(ram_csb), 64'({NB{1'b1}}));
    chk("abort rvalid", 64'(cpu_rvalid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (cpu_rvalid || wbs_ack) pulses++;
    end
    chk("abort no response", 64'(pulses), 64'd0);

`ifdef HS32_SRAM_WB_PORT_EN
    begin
      logic [17:0] seq, exp_seq;
      int rv, ak;
      logic [31:0] wrd;
      // Simultaneous requests straight after reset: CPU, WB, CPU.
      seq = '0; exp_seq = '0; rv = 0; ak = 0; wrd = '0;
      @(negedge clk);
      cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h404;
      wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_adr = 32'h808; wbs_sel = 4'hF;
      for (int c = 0; c < 9; c++) begin
        #1;
        if (cpu_ready) seq[2*c +: 2] = 2'd1;
        else if (ram_csb != '1) seq[2*c +: 2] = 2'd2;
        if (c % 3 == 0) exp_seq[2*c +: 2] = ((c / 3) % 2 == 0) ? 2'd1 : 2'd2;
        if (cpu_rvalid) rv++;
        if (wbs_ack) begin ak++; wrd = wbs_dat_r; end
        @(negedge clk);
      end
      cpu_valid = 1'b0; wbs_cyc = 1'b0; wbs_stb = 1'b0;
      chk("rr grant order", 64'(seq), 64'(exp_seq));
      chk("rr cpu responses", 64'(rv), 64'd2);
      chk("rr wb acks", 64'(ak), 64'd1);
      chk("rr wb data", 64'(wrd), 64'(ref_read(32'h808)));
      @(negedge clk);

      // Cross-port write/read and WB decode error.
      wb_xfer(1'b1, 32'h0C0, 32'h55667788, 4'h6, "wb write", wrd);
      ref_apply(1'b1, 32'h0C0, 32'h55667788, 4'h6);
      cpu_xfer(1'b0, 32'h0C0, 32'h0, 4'h0, "cpu after wb", rd, er);
      chk("cpu after wb rdata", 64'(rd), 64'(ref_read(32'h0C0)));
      wb_xfer(1'b0, 32'h404, 32'h0, 4'hF, "wb read", wrd);
      chk("wb read data", 64'(wrd), 64'(ref_read(32'h404)));
      wb_xfer(1'b0, 32'h2000, 32'h0, 4'hF, "wb err", wrd);
      chk("wb err data", 64'(wrd), 64'd0);

      // Master abandons the cycle mid-access: no ack, controller recovers.
      @(negedge clk);
      wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_adr = 32'h404;
      #1 chk("wb drop csb", 64'(ram_csb), 64'(4'b1101));
      @(posedge clk); #1 wbs_cyc = 1'b0; wbs_stb = 1'b0;
      ak = 0;
      for (int c = 0; c < 5; c++) begin @(negedge clk); if (wbs_ack) ak++; end
      chk("wb drop no ack", 64'(ak), 64'd0);
      cpu_xfer(1'b0, 32'h404, 32'h0, 4'h0, "after drop", rd, er);
      chk("after drop rdata", 64'(rd), 64'(ref_read(32'h404)));
    end
`else
    begin
      int ak;
      // WB port absent: a held strobe is never acknowledged nor blocks the CPU.
      @(negedge clk);
      wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_adr = 32'h404; wbs_sel = 4'hF;
      cpu_xfer(1'b0, 32'h404, 32'h0, 4'h0, "cpu with wb stb", rd, er);
      chk("cpu with wb stb rdata", 64'(rd), 64'(ref_read(32'h404)));
      ak = 0;
      for (int c = 0; c < 6; c++) begin @(negedge clk); if (wbs_ack) ak++; end
      chk("wb disabled ack", 64'(ak), 64'd0);
      chk("wb disabled dat", 64'(wbs_dat_r), 64'd0);
      wbs_cyc = 1'b0; wbs_stb = 1'b0;
    end
`endif

    // Randomized accesses against the reference memory.
    for (int i = 0; i < 60; i++) begin
      logic        we;
      logic [31:0] a, d;
      logic [3:0]  m;
      we = 1'($urandom);
      d  = $urandom;
      m  = 4'($urandom);
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h1000;
      else a = 32'($urandom_range(0, NB - 1) * BANK_BYTES)
             + 32'((($urandom_range(0, 3) == 3) ? 255 : $urandom_range(0, 2)) * 4)
             + 32'($urandom_range(0, 3));
      cpu_xfer(we, a, d, m, $sformatf("rnd%0d", i), rd, er);
      chk($sformatf("rnd%0d err", i), 64'(er), 64'(is_err(a)));
      if (!we) chk($sformatf("rnd%0d rdata a=%0h", i, a), 64'(rd), 64'(ref_read(a)));
      ref_apply(we, a, d, m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
